// File: rtl/task_pkt_pkg.sv
// task_pkt_pkg: shared state encoding, latency width and pointer sizing for the packet packer.
package task_pkt_pkg;
  typedef enum logic [1:0] {IDLE, FILL, READY, SEND} state_t;
  localparam int LAT_W = 32;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/task_pkt_packer_if.sv
// task_pkt_packer_if: byte ingress, word egress and status signals of the packet packer.
interface task_pkt_packer_if #(parameter int WORD_BYTES = 4, parameter int SIZE_W = 12);
  logic [7:0] i_tdata;
  logic i_tdata_valid;
  logic i_tdata_last;
  logic o_tready;
  logic i_tmanager_ready;
  logic o_tanswer_ready;
  logic [8*WORD_BYTES-1:0] o_tdata;
  logic o_tdata_valid;
  logic o_tdata_last;
  logic [SIZE_W-1:0] o_packet_size_in_bytes;
  logic o_overflow;
  modport slave(input i_tdata, i_tdata_valid, i_tdata_last, i_tmanager_ready,
                output o_tready, o_tanswer_ready, o_tdata, o_tdata_valid, o_tdata_last,
                o_packet_size_in_bytes, o_overflow);
  modport master(output i_tdata, i_tdata_valid, i_tdata_last, i_tmanager_ready,
                 input o_tready, o_tanswer_ready, o_tdata, o_tdata_valid, o_tdata_last,
                 o_packet_size_in_bytes, o_overflow);
endinterface

// File: rtl/task_pkt_fifo.sv
// task_pkt_fifo: single-clock word buffer with registered read; full asserts RESERVE words early.
module task_pkt_fifo import task_pkt_pkg::*; #(
  parameter int W = 32,
  parameter int DEPTH = 128,
  parameter int RESERVE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = ptr_w(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  always_ff @(posedge i_clk)
    if (wr_en) mem[wp[PW-1:0]] <= wr_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wp <= '0;
      rp <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) begin
        rp <= rp + 1'b1;
        rd_data <= mem[rp[PW-1:0]];
      end
    end
  assign full = (wp - rp) == (PW+1)'(DEPTH - RESERVE);
  assign empty = wp == rp;
endmodule

// File: rtl/task_pkt_packer.sv
// task_pkt_packer: packs bytes little-endian into words, buffers one packet, then streams it out.
// Define TASK_PKT_LAT_EN to append a saturating ingress-latency word after the data words.
module task_pkt_packer import task_pkt_pkg::*; #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH = 128,
  parameter int SIZE_W = 12
) (
  input logic i_clk,
  input logic i_rst_n,
  task_pkt_packer_if.slave bus
);
  localparam int W = 8*WORD_BYTES;
  localparam int LW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
`ifdef TASK_PKT_LAT_EN
  localparam int RES = 1;
  localparam int EXTRA = WORD_BYTES;
`else
  localparam int RES = 0;
  localparam int EXTRA = 0;
`endif
  state_t state_q, state_d;
  logic [W-1:0] pack_q, pack_nx, rd_data, word;
  logic [LW-1:0] lane_q;
  logic [SIZE_W-1:0] cnt_q;
  logic ovf_q, head_v_q, tready, accept, word_end, push, pop, full, empty, have, issue, last_word;
  assign tready = i_rst_n && (state_q == IDLE || state_q == FILL);
  assign accept = tready && bus.i_tdata_valid;
  assign word_end = lane_q == LW'(WORD_BYTES-1) || bus.i_tdata_last;
  assign push = accept && word_end && !full;
  assign pack_nx = pack_q | (W'(bus.i_tdata) << (8*lane_q));
`ifdef TASK_PKT_LAT_EN
  logic [LAT_W-1:0] lat_q;
  logic lat_done_q;
  assign have = head_v_q || !lat_done_q;
  assign word = head_v_q ? rd_data : W'(lat_q);
  assign last_word = !head_v_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      lat_q <= '0;
      lat_done_q <= 1'b1;
    end else begin
      if (accept && state_q == IDLE) begin
        lat_q <= LAT_W'(1);
        lat_done_q <= 1'b0;
      end else if (state_q == FILL && !(&lat_q)) lat_q <= lat_q + 1'b1;
      if (issue && !head_v_q) lat_done_q <= 1'b1;
    end
`else
  assign have = head_v_q;
  assign word = rd_data;
  assign last_word = empty;
`endif
  assign issue = state_q == SEND && bus.i_tmanager_ready && have;
  // the fifo's read register is the presented word, so it is prefetched in READY
  assign pop = !empty && ((state_q == READY && !head_v_q) || (issue && head_v_q));
  task_pkt_fifo #(.W(W), .DEPTH(DEPTH), .RESERVE(RES)) u_fifo (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .wr_en(push), .wr_data(pack_nx),
    .rd_en(pop), .rd_data(rd_data), .full(full), .empty(empty)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE  ? (accept ? (bus.i_tdata_last ? READY : FILL) : IDLE) :
              state_q == FILL  ? (accept && bus.i_tdata_last ? READY : FILL) :
              state_q == READY ? (bus.i_tmanager_ready ? SEND : READY) :
                                 (issue && last_word ? IDLE : SEND);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      pack_q <= '0;
      lane_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      head_v_q <= 1'b0;
    end else begin
      if (accept) begin
        ovf_q <= state_q != IDLE && (ovf_q || full);
        if (!full) begin
          cnt_q <= state_q == IDLE ? SIZE_W'(1) : cnt_q + 1'b1;
          pack_q <= word_end ? '0 : pack_nx;
          lane_q <= word_end ? '0 : lane_q + 1'b1;
        end
      end
      head_v_q <= pop ? 1'b1 : (issue && head_v_q) ? 1'b0 : head_v_q;
    end
  assign bus.o_tready = tready;
  assign bus.o_tanswer_ready = state_q == READY || state_q == SEND;
  assign bus.o_tdata = issue ? word : '0;
  assign bus.o_tdata_valid = issue;
  assign bus.o_tdata_last = issue && last_word;
  assign bus.o_packet_size_in_bytes = bus.o_tanswer_ready ? cnt_q + SIZE_W'(EXTRA) : '0;
  assign bus.o_overflow = ovf_q;
endmodule

// File: doc/task_pkt_packer.md
TASK_PKT_PACKER -- requirements
Module: task_pkt_packer

Interface
REQ-001 SHALL have parameter WORD_BYTES, default 4: bytes per output word; output width is 8*WORD_BYTES.
REQ-002 SHALL have parameter DEPTH, default 128: buffer capacity in words, power of two.
REQ-003 SHALL have parameter SIZE_W, default 12: width of the packet-size output.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_tdata, input, 8: ingress byte.
REQ-007 SHALL have port i_tdata_valid, input, 1: ingress byte valid.
REQ-008 SHALL have port i_tdata_last, input, 1: final byte of the packet; qualified by valid.
REQ-009 SHALL have port o_tready, output, 1: ingress request; a byte is accepted when valid and o_tready are both high.
REQ-010 SHALL have port i_tmanager_ready, input, 1: egress consumer ready.
REQ-011 SHALL have port o_tanswer_ready, output, 1: complete packet buffered and available.
REQ-012 SHALL have port o_tdata, output, 8*WORD_BYTES: egress word.
REQ-013 SHALL have port o_tdata_valid, output, 1: egress word valid.
REQ-014 SHALL have port o_tdata_last, output, 1: final egress word.
REQ-015 SHALL have port o_packet_size_in_bytes, output, SIZE_W: egress packet length in bytes.
REQ-016 SHALL have port o_overflow, output, 1: the current packet exceeded DEPTH words.

Function
REQ-017 SHALL use states IDLE, FILL, READY, SEND.
- IDLE->FILL on first accepted byte.
- FILL->READY on the edge that accepts the last byte.
- READY->SEND when i_tmanager_ready is high.
- SEND->IDLE one cycle after the last word is issued.
REQ-018 SHALL drive o_tready high only in IDLE and FILL; i_tdata_valid SHALL be ignored in READY and SEND.
REQ-019 SHALL pack bytes little-endian: the first byte of a word goes to bits [7:0].
REQ-020 SHALL zero-pad a partial final word and push it on the same edge that accepts the last byte.
REQ-021 SHALL count accepted bytes; o_packet_size_in_bytes SHALL be held stable from READY entry until return to IDLE, and be 0 otherwise.
REQ-022 SHALL drive o_tanswer_ready high in READY and SEND only.
REQ-023 SHALL issue one registered word per cycle in SEND while i_tmanager_ready is high; while it is low, o_tdata_valid SHALL be low and the read pointer SHALL hold.
REQ-024 SHALL assert o_tdata_last together with o_tdata_valid on the final word only.
REQ-025 SHALL, once DEPTH words are stored without a last byte, keep o_tready high, discard further bytes, saturate the size at DEPTH*WORD_BYTES, and set o_overflow.
REQ-026 SHALL clear o_overflow when the next packet's first byte is accepted.
REQ-027 SHALL handle a single-byte packet (valid and last together in IDLE) as one padded word of size 1.
REQ-028 SHALL handle a packet of exactly DEPTH*WORD_BYTES bytes without setting o_overflow.

Reset
REQ-029 SHALL, on i_rst_n low (at any time, including mid-packet), immediately force:
- state = IDLE, pointers, counters and packing register = 0;
- all outputs = 0, except o_tready = 1 once reset is released.
REQ-030 SHALL NOT emit any partial packet after reset is released.

Configuration
REQ-031 SHALL support macro TASK_PKT_LAT_EN.
- Defined: a 32-bit saturating latency word is appended as the final egress word. Value = accept edge of last byte − accept edge of first byte + 1. Reported size includes WORD_BYTES extra, and o_tdata_last moves to the latency word. One buffer word SHALL be reserved for it, so overflow is at DEPTH-1 data words. For WORD_BYTES < 4 the word is truncated to 8*WORD_BYTES bits; for WORD_BYTES > 4 it is zero-extended.
- Undefined: no latency counter or word; size equals the byte count.

Structure
REQ-032 SHALL place the following in package task_pkt_pkg: state enum, LAT_W=32, and a function deriving the pointer width from DEPTH.
REQ-033 SHALL implement the word buffer as sub-module task_pkt_fifo: synchronous, single clock, registered read, with full and empty flags.

Verification
REQ-034 SHALL cover: WORD_BYTES=4, bytes 11,22,33,44 (last on 44), tmanager ready -> one word 0x44332211 with last, size 4; with LAT_EN, size 8 and second word 0x00000004.
REQ-035 SHALL cover: 5 bytes 01..05 -> words 0x04030201, 0x00000005 (last), size 5.
REQ-036 SHALL cover: DEPTH=4 without LAT_EN, 20 bytes -> o_overflow=1, size 16, four words issued, o_tready never low during fill.
REQ-037 SHALL cover: i_tmanager_ready toggled 1,0,0,1 during an 8-byte packet SEND -> two words, no duplicates or gaps, o_tdata_valid low during the stall.
REQ-038 SHALL cover: i_rst_n pulsed low after 3 bytes, then a 4-byte packet AA..DD -> only 0xDDCCBBAA issued, size 4.
REQ-039 SHALL cover: single byte 7F with last -> word 0x0000007F, size 1, o_tdata_last on the first word (without LAT_EN).
